wb_ctrl: RTL and testbench
==========================

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 15: max cycles waited for dmem_ack_in before a load is abandoned (legal 1..255).
REQ-002 clk_in  input  1  single clock; all state on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 ex_valid_in  input  1  execute stage presents a retiring instruction.
REQ-005 ex_ready_out  output  1  wb_ctrl can accept an instruction this cycle.
REQ-006 ex_rd_addr_in  input  5  destination register.
REQ-007 ex_wb_sel_in  input  3  writeback source select (000 alu, 001 load, 010 imm, 011 iadder, 101 pc+4).
REQ-008 ex_rf_wr_in  input  1  instruction writes the register file.
REQ-009 ex_is_load_in  input  1  instruction is a load.
REQ-010 flush_in  input  1  kill pending and incoming instruction.
REQ-011 dmem_ack_in  input  1  load data valid on the load data path this cycle.
REQ-012 wb_mux_sel_reg_out  output  3  registered select driving the writeback mux.
REQ-013 rd_addr_reg_out  output  5  registered destination register.
REQ-014 rf_wr_en_out  output  1  register file write strobe.
REQ-015 stall_out  output  1  pipeline stall request.
REQ-016 load_fault_out  output  1  one-cycle pulse on load timeout.
REQ-017 retire_cnt_out  output  16  count of completed instructions.

Function
REQ-018 States: IDLE, WB, LWAIT; 8-bit wait counter; pending-write flag.
REQ-019 Accept = ex_valid_in & ex_ready_out & ~flush_in; ex_ready_out = 1 in IDLE and WB, 0 in LWAIT (combinational from state).
REQ-020 Accept, non-load: next state WB; capture select, rd, and write flag = ex_rf_wr_in & (rd != 0).
REQ-021 Select capture: legal codes pass through; 100, 110, 111 captured as 000.
REQ-022 In WB: rf_wr_en_out = captured write flag for exactly that cycle; retire_cnt increments by 1; next state WB on new accept, else IDLE.
REQ-023 Accept, load: next state LWAIT; wb_mux_sel_reg_out = 001; counter cleared to 0; pending-write flag = ex_rf_wr_in & (rd != 0).
REQ-024 In LWAIT: stall_out = 1; rf_wr_en_out = dmem_ack_in & pending-write (same-cycle, combinational); counter increments each cycle without ack.
REQ-025 LWAIT with dmem_ack_in: retire_cnt increments; next state IDLE.
REQ-026 LWAIT, counter == LOAD_TIMEOUT with no ack: no write; load_fault_out = 1 next cycle only; next state IDLE; retire_cnt unchanged.
REQ-027 flush_in in LWAIT: no write, no retire, no fault, next state IDLE; flush_in wins over same-cycle dmem_ack_in and timeout.
REQ-028 flush_in in WB: rf_wr_en_out forced 0 that cycle, no retire; no instruction accepted; next state IDLE.
REQ-029 stall_out = 0 in IDLE and WB.
REQ-030 In IDLE: rf_wr_en_out = 0; registered outputs hold last value.
REQ-031 retire_cnt_out wraps 0xFFFF -> 0x0000.
REQ-032 dmem_ack_in outside LWAIT is ignored.

Reset
REQ-033 rst_in low: immediately state IDLE; wb_mux_sel_reg_out = 000, rd_addr_reg_out = 0, rf_wr_en_out = 0, stall_out = 0, load_fault_out = 0, retire_cnt_out = 0, counter and flags 0; ex_ready_out = 1.
REQ-034 Reset asserted mid-LWAIT abandons the load; no write or fault after release.
REQ-035 First accept possible on the first rising edge after rst_in rises.

Verification
REQ-036 Back-to-back accepts rd=5 sel=000 then rd=6 sel=101 -> WB two cycles, rf_wr_en_out=1 both, rd_addr_reg_out 5 then 6, sel 000 then 101, retire_cnt_out=2.
REQ-037 Load rd=7, ack after 3 wait cycles -> stall_out=1 and ex_ready_out=0 for 4 cycles, rf_wr_en_out=1 only in ack cycle, sel 001, then IDLE.
REQ-038 Load rd=7, no ack, LOAD_TIMEOUT=15 -> no write, load_fault_out one-cycle pulse, retire_cnt_out unchanged, ex_ready_out returns 1.
REQ-039 Load pending, flush_in and dmem_ack_in same cycle -> rf_wr_en_out=0, no retire, IDLE next.
REQ-040 Accept rd=0 with ex_rf_wr_in=1, then sel=111 rd=3 -> first: rf_wr_en_out=0 but retire counted; second: sel captured 000, write to rd 3.
REQ-041 retire_cnt_out at 0xFFFF plus one retire -> 0x0000; rst_in low mid-LWAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - writeback stage controller: register-file write sequencing, load wait with timeout, retire count
module wb_ctrl #(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ex_valid_in,
    output logic        ex_ready_out,
    input  logic [4:0]  ex_rd_addr_in,
    input  logic [2:0]  ex_wb_sel_in,
    input  logic        ex_rf_wr_in,
    input  logic        ex_is_load_in,
    input  logic        flush_in,
    input  logic        dmem_ack_in,
    output logic [2:0]  wb_mux_sel_reg_out,
    output logic [4:0]  rd_addr_reg_out,
    output logic        rf_wr_en_out,
    output logic        stall_out,
    output logic        load_fault_out,
    output logic [15:0] retire_cnt_out
);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_LWAIT} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(LOAD_TIMEOUT);

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [4:0]  rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [15:0] retire_q, retire_d;
    logic        accept;

    assign accept = ex_valid_in & ex_ready_out & ~flush_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            sel_q    <= 3'b000;
            rd_q     <= 5'd0;
            wr_q     <= 1'b0;
            cnt_q    <= 8'd0;
            fault_q  <= 1'b0;
            retire_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        fault_d  = 1'b0;
        retire_d = retire_q;
        case (state_q)
            S_IDLE, S_WB: begin
                if (state_q == S_WB && !flush_in)
                    retire_d = retire_q + 16'd1;
                if (accept) begin
                    rd_d = ex_rd_addr_in;
                    wr_d = ex_rf_wr_in & (ex_rd_addr_in != 5'd0);
                    if (ex_is_load_in) begin
                        state_d = S_LWAIT;
                        sel_d   = 3'b001;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_WB;
                        // Unused encodings fall back to the ALU result
                        case (ex_wb_sel_in)
                            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: sel_d = ex_wb_sel_in;
                            default:                                sel_d = 3'b000;
                        endcase
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LWAIT: begin
                if (flush_in) begin
                    state_d = S_IDLE;
                end else if (dmem_ack_in) begin
                    state_d  = S_IDLE;
                    retire_d = retire_q + 16'd1;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ex_ready_out = 1'b1;
        stall_out    = 1'b0;
        rf_wr_en_out = 1'b0;
        case (state_q)
            S_WB:    rf_wr_en_out = wr_q & ~flush_in;
            S_LWAIT: begin
                ex_ready_out = 1'b0;
                stall_out    = 1'b1;
                rf_wr_en_out = dmem_ack_in & wr_q & ~flush_in;
            end
            default: ;
        endcase
    end

    assign wb_mux_sel_reg_out = sel_q;
    assign rd_addr_reg_out    = rd_q;
    assign load_fault_out     = fault_q;
    assign retire_cnt_out     = retire_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// tb/tb_wb_ctrl.sv - directed self-checking bench for wb_ctrl
module tb_wb_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        ex_valid_in, ex_ready_out;
    logic [4:0]  ex_rd_addr_in;
    logic [2:0]  ex_wb_sel_in;
    logic        ex_rf_wr_in, ex_is_load_in, flush_in, dmem_ack_in;
    logic [2:0]  wb_mux_sel_reg_out;
    logic [4:0]  rd_addr_reg_out;
    logic        rf_wr_en_out, stall_out, load_fault_out;
    logic [15:0] retire_cnt_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_retire = 16'd0;

    wb_ctrl #(.LOAD_TIMEOUT(15)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .ex_valid_in(ex_valid_in), .ex_ready_out(ex_ready_out),
        .ex_rd_addr_in(ex_rd_addr_in), .ex_wb_sel_in(ex_wb_sel_in),
        .ex_rf_wr_in(ex_rf_wr_in), .ex_is_load_in(ex_is_load_in),
        .flush_in(flush_in), .dmem_ack_in(dmem_ack_in),
        .wb_mux_sel_reg_out(wb_mux_sel_reg_out), .rd_addr_reg_out(rd_addr_reg_out),
        .rf_wr_en_out(rf_wr_en_out), .stall_out(stall_out),
        .load_fault_out(load_fault_out), .retire_cnt_out(retire_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_in();
        ex_valid_in = 0; ex_rd_addr_in = 0; ex_wb_sel_in = 0; ex_rf_wr_in = 0;
        ex_is_load_in = 0; flush_in = 0; dmem_ack_in = 0;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [2:0] sel, input logic wr, input logic ld);
        ex_valid_in = 1; ex_rd_addr_in = rd; ex_wb_sel_in = sel; ex_rf_wr_in = wr; ex_is_load_in = ld;
        #1;
    endtask

    task automatic test_reset();
        rst_in = 0; idle_in(); #2;
        n_checks++; if (wb_mux_sel_reg_out !== 3'b000) begin n_fail++; $display("FAIL reset_sel got %b exp 000", wb_mux_sel_reg_out); end
        n_checks++; if (rd_addr_reg_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d exp 0", rd_addr_reg_out); end
        n_checks++; if ({rf_wr_en_out, stall_out, load_fault_out, ex_ready_out} !== 4'b0001) begin n_fail++; $display("FAIL reset_flags got %b exp 0001", {rf_wr_en_out, stall_out, load_fault_out, ex_ready_out}); end
        n_checks++; if (retire_cnt_out !== 16'd0) begin n_fail++; $display("FAIL reset_retire got %0d exp 0", retire_cnt_out); end
        cyc(); cyc();
        rst_in = 1;
    endtask

    task automatic test_back_to_back();
        drive(5, 3'b000, 1, 0);
        n_checks++; if (ex_ready_out !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", ex_ready_out); end
        cyc(); drive(6, 3'b101, 1, 0);
        n_checks++; if ({rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out} !== {1'b1, 5'd5, 3'b000}) begin n_fail++; $display("FAIL b2b_first got wr=%b rd=%0d sel=%b exp wr=1 rd=5 sel=000", rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out); end
        cyc(); idle_in(); #1;
        n_checks++; if ({rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out} !== {1'b1, 5'd6, 3'b101}) begin n_fail++; $display("FAIL b2b_second got wr=%b rd=%0d sel=%b exp wr=1 rd=6 sel=101", rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out); end
        cyc(); exp_retire += 2;
        n_checks++; if ({rf_wr_en_out, stall_out} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle got wr=%b stall=%b exp 0 0", rf_wr_en_out, stall_out); end
        n_checks++; if (retire_cnt_out !== exp_retire) begin n_fail++; $display("FAIL b2b_retire got %0d exp %0d", retire_cnt_out, exp_retire); end
    endtask

    task automatic test_load_ack();
        drive(7, 3'b001, 1, 1);
        cyc(); idle_in(); #1;
        for (int i = 0; i < 4; i++) begin
            dmem_ack_in = (i == 3); #1;
            n_checks++; if ({stall_out, ex_ready_out, wb_mux_sel_reg_out} !== {1'b1, 1'b0, 3'b001}) begin n_fail++; $display("FAIL load_wait%0d got stall=%b ready=%b sel=%b exp 1 0 001", i, stall_out, ex_ready_out, wb_mux_sel_reg_out); end
            n_checks++; if (rf_wr_en_out !== (i == 3)) begin n_fail++; $display("FAIL load_wr%0d got %b exp %b", i, rf_wr_en_out, (i == 3)); end
            cyc();
        end
        idle_in(); #1; exp_retire += 1;
        n_checks++; if ({stall_out, ex_ready_out, rf_wr_en_out} !== 3'b010) begin n_fail++; $display("FAIL load_done got %b exp 010", {stall_out, ex_ready_out, rf_wr_en_out}); end
        n_checks++; if (retire_cnt_out !== exp_retire) begin n_fail++; $display("FAIL load_retire got %0d exp %0d", retire_cnt_out, exp_retire); end
    endtask

    task automatic test_load_timeout();
        drive(7, 3'b001, 1, 1);
        cyc(); idle_in(); #1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if ({stall_out, rf_wr_en_out, load_fault_out} !== 3'b100) begin n_fail++; $display("FAIL tmo_wait%0d got %b exp 100", i, {stall_out, rf_wr_en_out, load_fault_out}); end
            cyc();
        end
        n_checks++; if ({load_fault_out, ex_ready_out, stall_out, rf_wr_en_out} !== 4'b1100) begin n_fail++; $display("FAIL tmo_fault got %b exp 1100", {load_fault_out, ex_ready_out, stall_out, rf_wr_en_out}); end
        n_checks++; if (retire_cnt_out !== exp_retire) begin n_fail++; $display("FAIL tmo_retire got %0d exp %0d", retire_cnt_out, exp_retire); end
        cyc();
        n_checks++; if (load_fault_out !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse got %b exp 0", load_fault_out); end
    endtask

    task automatic test_flush_ack();
        drive(7, 3'b001, 1, 1);
        cyc(); idle_in(); #1;
        cyc(); flush_in = 1; dmem_ack_in = 1; #1;
        n_checks++; if (rf_wr_en_out !== 1'b0) begin n_fail++; $display("FAIL flush_ack_wr got %b exp 0", rf_wr_en_out); end
        cyc(); idle_in(); #1;
        n_checks++; if ({stall_out, ex_ready_out, load_fault_out} !== 3'b010) begin n_fail++; $display("FAIL flush_ack_idle got %b exp 010", {stall_out, ex_ready_out, load_fault_out}); end
        n_checks++; if (retire_cnt_out !== exp_retire) begin n_fail++; $display("FAIL flush_ack_retire got %0d exp %0d", retire_cnt_out, exp_retire); end
    endtask

    task automatic test_rd_zero_sel();
        drive(0, 3'b000, 1, 0);
        cyc(); drive(3, 3'b111, 1, 0);
        n_checks++; if (rf_wr_en_out !== 1'b0) begin n_fail++; $display("FAIL rd0_wr got %b exp 0", rf_wr_en_out); end
        cyc(); idle_in(); #1; exp_retire += 1;
        n_checks++; if ({rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out} !== {1'b1, 5'd3, 3'b000}) begin n_fail++; $display("FAIL sel111 got wr=%b rd=%0d sel=%b exp 1 3 000", rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out); end
        n_checks++; if (retire_cnt_out !== exp_retire) begin n_fail++; $display("FAIL rd0_retire got %0d exp %0d", retire_cnt_out, exp_retire); end
        cyc(); exp_retire += 1;
        n_checks++; if (retire_cnt_out !== exp_retire) begin n_fail++; $display("FAIL sel111_retire got %0d exp %0d", retire_cnt_out, exp_retire); end
    endtask

    task automatic test_flush_wb();
        drive(9, 3'b010, 1, 0);
        cyc(); drive(4, 3'b011, 1, 0); flush_in = 1; #1;
        n_checks++; if (rf_wr_en_out !== 1'b0) begin n_fail++; $display("FAIL flush_wb_wr got %b exp 0", rf_wr_en_out); end
        cyc(); idle_in(); #1;
        n_checks++; if ({rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out} !== {1'b0, 5'd9, 3'b010}) begin n_fail++; $display("FAIL flush_wb_idle got wr=%b rd=%0d sel=%b exp 0 9 010", rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out); end
        n_checks++; if (retire_cnt_out !== exp_retire) begin n_fail++; $display("FAIL flush_wb_retire got %0d exp %0d", retire_cnt_out, exp_retire); end
        dmem_ack_in = 1; #1;
        n_checks++; if ({rf_wr_en_out, stall_out} !== 2'b00) begin n_fail++; $display("FAIL ack_idle got %b exp 00", {rf_wr_en_out, stall_out}); end
        cyc(); idle_in(); #1;
        n_checks++; if (retire_cnt_out !== exp_retire) begin n_fail++; $display("FAIL ack_idle_retire got %0d exp %0d", retire_cnt_out, exp_retire); end
    endtask

    task automatic test_wrap();
        int n;
        n = 65535 - int'(exp_retire);
        drive(1, 3'b000, 1, 0);
        for (int i = 0; i < n; i++) cyc();
        idle_in(); #1;
        cyc();
        n_checks++; if (retire_cnt_out !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff got %h exp ffff", retire_cnt_out); end
        drive(2, 3'b000, 1, 0);
        cyc(); idle_in(); #1;
        cyc();
        n_checks++; if (retire_cnt_out !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h exp 0000", retire_cnt_out); end
    endtask

    task automatic test_reset_mid_lwait();
        drive(12, 3'b001, 1, 1);
        cyc(); idle_in(); #1;
        cyc(); #2;
        rst_in = 0; #1;
        n_checks++; if ({stall_out, ex_ready_out, rf_wr_en_out, load_fault_out} !== 4'b0100) begin n_fail++; $display("FAIL rst_async_flags got %b exp 0100", {stall_out, ex_ready_out, rf_wr_en_out, load_fault_out}); end
        n_checks++; if ({wb_mux_sel_reg_out, rd_addr_reg_out, retire_cnt_out} !== 24'd0) begin n_fail++; $display("FAIL rst_async_regs got sel=%b rd=%0d cnt=%0d exp 0", wb_mux_sel_reg_out, rd_addr_reg_out, retire_cnt_out); end
        cyc();
        rst_in = 1;
        drive(8, 3'b010, 1, 0);
        cyc(); idle_in(); dmem_ack_in = 1; #1;
        n_checks++; if ({rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out} !== {1'b1, 5'd8, 3'b010}) begin n_fail++; $display("FAIL first_accept got wr=%b rd=%0d sel=%b exp 1 8 010", rf_wr_en_out, rd_addr_reg_out, wb_mux_sel_reg_out); end
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_checks++; if ({rf_wr_en_out, load_fault_out, stall_out} !== 3'b000) begin n_fail++; $display("FAIL post_rst%0d got %b exp 000", i, {rf_wr_en_out, load_fault_out, stall_out}); end
        end
        n_checks++; if (retire_cnt_out !== 16'd1) begin n_fail++; $display("FAIL post_rst_retire got %0d exp 1", retire_cnt_out); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_ack();
        test_load_timeout();
        test_flush_ack();
        test_rd_zero_sel();
        test_flush_wb();
        test_wrap();
        test_reset_mid_lwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
